// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter for 8 requesters with a per-grant hold limit.
// A grant lasts until the holder drops its request or has held it for MAX_HOLD
// cycles. The arbiter then searches again from the requester after the holder,
// and the next grant starts on the following cycle, with no idle cycle between.
module round_robin_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       gnt_new
);

  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;
  localparam int unsigned CW = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [CW-1:0] hold_cnt;

  logic [IW-1:0] start_c;
  logic [IW-1:0] cand_c;
  logic [IW-1:0] win_idx_c;
  logic          win_found_c;
  logic          release_c;

  // Search start: on a release the pointer is about to load gnt_idx+1, so use it now
  always_comb begin
    start_c = (state == GRANT) ? IW'(gnt_idx + IW'(1)) : ptr;
  end

  // Rotating priority search: the first asserted request at or after start_c wins
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = start_c;
    cand_c      = start_c;
    for (int k = 0; k < N; k++) begin
      cand_c = IW'(start_c + IW'(k));
      if (!win_found_c && req[cand_c]) begin
        win_found_c = 1'b1;
        win_idx_c   = cand_c;
      end
    end
  end

  // The holder gives up the grant when it stops requesting or its hold time has run out
  always_comb begin
    release_c = (state == GRANT) &&
                (!req[gnt_idx] || (hold_cnt == CW'(MAX_HOLD)));
  end

  // Arbitration FSM with registered grant outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      gnt_new   <= 1'b0;
    end else begin
      gnt_new <= 1'b0;
      case (state)
        IDLE: begin
          if (en && win_found_c) begin
            state     <= GRANT;
            gnt_idx   <= win_idx_c;
            gnt       <= 8'b1 << win_idx_c;
            gnt_valid <= 1'b1;
            gnt_new   <= 1'b1;
            hold_cnt  <= CW'(1);
          end
        end
        GRANT: begin
          if (release_c) begin
            ptr <= IW'(gnt_idx + IW'(1));
            if (en && win_found_c) begin
              gnt_idx  <= win_idx_c;
              gnt      <= 8'b1 << win_idx_c;
              gnt_new  <= 1'b1;
              hold_cnt <= CW'(1);
            end else begin
              state     <= IDLE;
              gnt       <= '0;
              gnt_idx   <= '0;
              gnt_valid <= 1'b0;
              hold_cnt  <= '0;
            end
          end else begin
            hold_cnt <= CW'(hold_cnt + CW'(1));
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Scenario bench for round_robin_arbiter (MAX_HOLD = 4).
// Each cycle's expected grant is queued as the inputs are driven, then checked after the clock edge.
module tb_round_robin_arbiter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       gnt_new;

  typedef struct packed {
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic       v;
    logic [2:0] idx;
    logic       nw;
  } row_t;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       nw;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  round_robin_arbiter #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .gnt_new   (gnt_new)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge
  task automatic apply_row(input row_t r);
    exp_t e;
    rst_n   = r.rst_n;
    en      = r.en;
    req     = r.req;
    e.valid = r.v;
    e.idx   = r.v ? r.idx : 3'd0;
    e.gnt   = r.v ? (8'b1 << r.idx) : 8'b0;
    e.nw    = r.nw;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      apply_row('{1'b0, 1'b1, 8'hFF, 1'b0, 3'd0, 1'b0});
      step();
      e = sb.pop_front();
      n_cmp++;
      if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_valid !== e.valid || gnt_new !== e.nw) begin
        n_err++;
        $display("FAIL reset[%0d]: got gnt=%b idx=%0d valid=%b new=%b, want gnt=%b idx=%0d valid=%b new=%b",
                 k, gnt, gnt_idx, gnt_valid, gnt_new, e.gnt, e.idx, e.valid, e.nw);
      end
    end
  endtask

  task automatic test_first_grant();
    row_t rows [3] = '{
      '{1'b1, 1'b1, 8'h01, 1'b1, 3'd0, 1'b1},
      '{1'b1, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0},
      '{1'b1, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0}
    };
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      apply_row(rows[k]);
      step();
      e = sb.pop_front();
      n_cmp++;
      if (gnt !== e.gnt || gnt_valid !== e.valid || gnt_new !== e.nw || (e.valid && gnt_idx !== e.idx)) begin
        n_err++;
        $display("FAIL first_grant[%0d]: got gnt=%b idx=%0d valid=%b new=%b, want gnt=%b idx=%0d valid=%b new=%b",
                 k, gnt, gnt_idx, gnt_valid, gnt_new, e.gnt, e.idx, e.valid, e.nw);
      end
    end
  endtask

  task automatic test_decode();
    exp_t e;
    row_t r;
    for (int i = 0; i < 8; i++) begin
      for (int ph = 0; ph < 2; ph++) begin
        if (ph == 0) r = '{1'b1, 1'b1, 8'b1 << i, 1'b1, 3'(i), 1'b1};
        else         r = '{1'b1, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};
        apply_row(r);
        step();
        e = sb.pop_front();
        n_cmp++;
        if (gnt !== e.gnt || gnt_valid !== e.valid || gnt_new !== e.nw || (e.valid && gnt_idx !== e.idx)) begin
          n_err++;
          $display("FAIL decode[%0d.%0d]: got gnt=%b idx=%0d valid=%b new=%b, want gnt=%b idx=%0d valid=%b new=%b",
                   i, ph, gnt, gnt_idx, gnt_valid, gnt_new, e.gnt, e.idx, e.valid, e.nw);
        end
      end
    end
  endtask

  task automatic test_rotation();
    exp_t e;
    row_t r;
    for (int k = 0; k < 37; k++) begin
      if (k == 0) r = '{1'b0, 1'b1, 8'hFF, 1'b0, 3'd0, 1'b0};
      else        r = '{1'b1, 1'b1, 8'hFF, 1'b1, 3'(((k - 1) / 4) % 8), ((k - 1) % 4) == 0};
      apply_row(r);
      step();
      e = sb.pop_front();
      n_cmp++;
      if (gnt !== e.gnt || gnt_valid !== e.valid || gnt_new !== e.nw || (e.valid && gnt_idx !== e.idx)) begin
        n_err++;
        $display("FAIL rotation[%0d]: got gnt=%b idx=%0d valid=%b new=%b, want gnt=%b idx=%0d valid=%b new=%b",
                 k, gnt, gnt_idx, gnt_valid, gnt_new, e.gnt, e.idx, e.valid, e.nw);
      end
    end
  endtask

  task automatic test_drop_switch();
    row_t rows [7] = '{
      '{1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0},
      '{1'b1, 1'b1, 8'h08, 1'b1, 3'd3, 1'b1},
      '{1'b1, 1'b1, 8'h2A, 1'b1, 3'd3, 1'b0},
      '{1'b1, 1'b1, 8'h22, 1'b1, 3'd5, 1'b1},
      '{1'b1, 1'b1, 8'h22, 1'b1, 3'd5, 1'b0},
      '{1'b1, 1'b1, 8'h02, 1'b1, 3'd1, 1'b1},
      '{1'b1, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0}
    };
    exp_t e;
    for (int k = 0; k < 7; k++) begin
      apply_row(rows[k]);
      step();
      e = sb.pop_front();
      n_cmp++;
      if (gnt !== e.gnt || gnt_valid !== e.valid || gnt_new !== e.nw || (e.valid && gnt_idx !== e.idx)) begin
        n_err++;
        $display("FAIL drop_switch[%0d]: got gnt=%b idx=%0d valid=%b new=%b, want gnt=%b idx=%0d valid=%b new=%b",
                 k, gnt, gnt_idx, gnt_valid, gnt_new, e.gnt, e.idx, e.valid, e.nw);
      end
    end
  endtask

  task automatic test_same_requester();
    exp_t e;
    row_t r;
    for (int k = 0; k < 13; k++) begin
      if (k == 0) r = '{1'b0, 1'b1, 8'h04, 1'b0, 3'd0, 1'b0};
      else        r = '{1'b1, 1'b1, 8'h04, 1'b1, 3'd2, ((k - 1) % 4) == 0};
      apply_row(r);
      step();
      e = sb.pop_front();
      n_cmp++;
      if (gnt !== e.gnt || gnt_valid !== e.valid || gnt_new !== e.nw || (e.valid && gnt_idx !== e.idx)) begin
        n_err++;
        $display("FAIL same_requester[%0d]: got gnt=%b idx=%0d valid=%b new=%b, want gnt=%b idx=%0d valid=%b new=%b",
                 k, gnt, gnt_idx, gnt_valid, gnt_new, e.gnt, e.idx, e.valid, e.nw);
      end
    end
  endtask

  task automatic test_en_hold();
    row_t rows [8] = '{
      '{1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0},
      '{1'b1, 1'b1, 8'h01, 1'b1, 3'd0, 1'b1},
      '{1'b1, 1'b0, 8'hFF, 1'b1, 3'd0, 1'b0},
      '{1'b1, 1'b0, 8'hFF, 1'b1, 3'd0, 1'b0},
      '{1'b1, 1'b0, 8'hFF, 1'b1, 3'd0, 1'b0},
      '{1'b1, 1'b0, 8'hFF, 1'b0, 3'd0, 1'b0},
      '{1'b1, 1'b0, 8'hFF, 1'b0, 3'd0, 1'b0},
      '{1'b1, 1'b0, 8'hFF, 1'b0, 3'd0, 1'b0}
    };
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      apply_row(rows[k]);
      step();
      e = sb.pop_front();
      n_cmp++;
      if (gnt !== e.gnt || gnt_valid !== e.valid || gnt_new !== e.nw || (e.valid && gnt_idx !== e.idx)) begin
        n_err++;
        $display("FAIL en_hold[%0d]: got gnt=%b idx=%0d valid=%b new=%b, want gnt=%b idx=%0d valid=%b new=%b",
                 k, gnt, gnt_idx, gnt_valid, gnt_new, e.gnt, e.idx, e.valid, e.nw);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    row_t rows [7] = '{
      '{1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0},
      '{1'b1, 1'b1, 8'h02, 1'b1, 3'd1, 1'b1},
      '{1'b1, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0},
      '{1'b1, 1'b1, 8'hFF, 1'b1, 3'd2, 1'b1},
      '{1'b0, 1'b1, 8'hFF, 1'b0, 3'd0, 1'b0},
      '{1'b1, 1'b1, 8'hFF, 1'b1, 3'd0, 1'b1},
      '{1'b1, 1'b1, 8'hFF, 1'b1, 3'd0, 1'b0}
    };
    exp_t e;
    for (int k = 0; k < 7; k++) begin
      apply_row(rows[k]);
      step();
      e = sb.pop_front();
      n_cmp++;
      if (gnt !== e.gnt || gnt_valid !== e.valid || gnt_new !== e.nw || (e.valid && gnt_idx !== e.idx)) begin
        n_err++;
        $display("FAIL reset_mid_grant[%0d]: got gnt=%b idx=%0d valid=%b new=%b, want gnt=%b idx=%0d valid=%b new=%b",
                 k, gnt, gnt_idx, gnt_valid, gnt_new, e.gnt, e.idx, e.valid, e.nw);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'h00;
    test_reset();
    test_first_grant();
    test_decode();
    test_rotation();
    test_drop_switch();
    test_same_requester();
    test_en_hold();
    test_reset_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
